// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: program counter, IF/ID pipeline register, halt
// detection and a running count of instructions delivered to decode.
module pc_fetch_stage #(
  parameter int unsigned           bit_size   = 18,
  parameter int unsigned           instr_size = 32,
  parameter logic [instr_size-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [bit_size-1:0]   next_pc,
  input  logic [instr_size-1:0] instr_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic [bit_size-1:0]   pc,
  output logic [bit_size-1:0]   pc_plus4,
  output logic [instr_size-1:0] ifid_instr,
  output logic [bit_size-1:0]   ifid_pc_plus4,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t                r_state;
  logic [bit_size-1:0]   r_pc;
  logic [instr_size-1:0] r_ifid_instr;
  logic [bit_size-1:0]   r_ifid_pc_plus4;
  logic                  r_ifid_valid;
  logic                  r_halted;
  logic [31:0]           r_fetch_count;

  state_t                w_state_nxt;
  logic [bit_size-1:0]   w_pc_nxt;
  logic [instr_size-1:0] w_ifid_instr_nxt;
  logic [bit_size-1:0]   w_ifid_pc_plus4_nxt;
  logic                  w_ifid_valid_nxt;
  logic                  w_halted_nxt;
  logic [31:0]           w_fetch_count_nxt;
  logic [bit_size-1:0]   w_pc_plus4;

  // Sequential address wraps modulo 2^bit_size.
  assign w_pc_plus4 = r_pc + bit_size'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_RUN;
      r_pc            <= '0;
      r_ifid_instr    <= '0;
      r_ifid_pc_plus4 <= '0;
      r_ifid_valid    <= 1'b0;
      r_halted        <= 1'b0;
      r_fetch_count   <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_ifid_instr    <= w_ifid_instr_nxt;
      r_ifid_pc_plus4 <= w_ifid_pc_plus4_nxt;
      r_ifid_valid    <= w_ifid_valid_nxt;
      r_halted        <= w_halted_nxt;
      r_fetch_count   <= w_fetch_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_ifid_instr_nxt    = r_ifid_instr;
    w_ifid_pc_plus4_nxt = r_ifid_pc_plus4;
    w_ifid_valid_nxt    = r_ifid_valid;
    w_halted_nxt        = r_halted;
    w_fetch_count_nxt   = r_fetch_count;

    unique case (r_state)
      S_RUN: begin
        if (flush) begin
          w_pc_nxt            = next_pc;
          w_ifid_instr_nxt    = '0;
          w_ifid_pc_plus4_nxt = '0;
          w_ifid_valid_nxt    = 1'b0;
        end else if (!stall) begin
          w_ifid_instr_nxt    = instr_in;
          w_ifid_pc_plus4_nxt = w_pc_plus4;
          w_ifid_valid_nxt    = 1'b1;
          w_fetch_count_nxt   = r_fetch_count + 32'd1;
          // The halt instruction is still delivered to decode, but pc stays on it.
          if (instr_in == HALT_INSTR) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end else begin
            w_pc_nxt = next_pc;
          end
        end
      end
      S_HALT: begin
        // Stall keeps the halt instruction visible to decode; otherwise drain.
        if (flush || !stall) begin
          w_ifid_instr_nxt = '0;
          w_ifid_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pc_plus4;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc_plus4 = r_ifid_pc_plus4;
  assign ifid_valid    = r_ifid_valid;
  assign halted        = r_halted;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with hand-computed expected values.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst;
  logic [17:0] next_pc;
  logic [31:0] instr_in;
  logic        stall;
  logic        flush;
  logic [17:0] pc;
  logic [17:0] pc_plus4;
  logic [31:0] ifid_instr;
  logic [17:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
  logic [31:0] fetch_count;

  logic        np_force;
  logic [17:0] np_val;
  logic        use_halt;

  int unsigned n_checks;
  int unsigned n_errors;

  // Instruction memory model: mem[a] = 32'hA500_0000 ^ a, or the halt word.
  assign instr_in = use_halt ? 32'hFFFF_FFFF : (32'hA500_0000 ^ {14'h0, pc});
  assign next_pc  = np_force ? np_val : pc_plus4;

  pc_fetch_stage #(
    .bit_size  (18),
    .instr_size(32),
    .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .next_pc      (next_pc),
    .instr_in     (instr_in),
    .stall        (stall),
    .flush        (flush),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"},    32'(pc), 32'h0);
    chk({tag, ".pp4"},   32'(pc_plus4), 32'h4);
    chk({tag, ".instr"}, ifid_instr, 32'h0);
    chk({tag, ".ipp4"},  32'(ifid_pc_plus4), 32'h0);
    chk({tag, ".valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, ".halt"},  32'(halted), 32'h0);
    chk({tag, ".cnt"},   fetch_count, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    np_force = 1'b0; np_val = '0; use_halt = 1'b0;

    tick(); tick();
    chk_reset("rst");
    tick();
    chk_reset("rst_hold");

    // Free-running fetch
    rst = 1'b1;
    tick();
    chk("run1.pc", 32'(pc), 32'h4);
    chk("run1.instr", ifid_instr, 32'hA500_0000);
    chk("run1.ipp4", 32'(ifid_pc_plus4), 32'h4);
    chk("run1.valid", 32'(ifid_valid), 32'h1);
    chk("run1.cnt", fetch_count, 32'd1);
    tick();
    chk("run2.pc", 32'(pc), 32'h8);
    chk("run2.ipp4", 32'(ifid_pc_plus4), 32'h8);
    chk("run2.cnt", fetch_count, 32'd2);

    // Stall two cycles at pc=8
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall.pc", 32'(pc), 32'h8);
      chk("stall.instr", ifid_instr, 32'hA500_0004);
      chk("stall.cnt", fetch_count, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("unstall.pc", 32'(pc), 32'hC);
    chk("unstall.instr", ifid_instr, 32'hA500_0008);
    chk("unstall.ipp4", 32'(ifid_pc_plus4), 32'hC);
    chk("unstall.cnt", fetch_count, 32'd3);
    tick();
    chk("pre_flush.pc", 32'(pc), 32'h10);

    // Flush with stall at pc=16, redirect to 0x100
    flush = 1'b1; stall = 1'b1; np_force = 1'b1; np_val = 18'h00100;
    tick();
    chk("flush.pc", 32'(pc), 32'h100);
    chk("flush.valid", 32'(ifid_valid), 32'h0);
    chk("flush.instr", ifid_instr, 32'h0);
    chk("flush.ipp4", 32'(ifid_pc_plus4), 32'h0);
    chk("flush.cnt", fetch_count, 32'd4);
    flush = 1'b0; stall = 1'b0; np_force = 1'b0;
    tick();
    chk("post_flush.instr", ifid_instr, 32'hA500_0100);
    chk("post_flush.ipp4", 32'(ifid_pc_plus4), 32'h104);
    chk("post_flush.valid", 32'(ifid_valid), 32'h1);
    chk("post_flush.cnt", fetch_count, 32'd5);

    // Address wrap
    np_force = 1'b1; np_val = 18'h3FFFC;
    tick();
    chk("wrap.pc", 32'(pc), 32'h3FFFC);
    chk("wrap.pp4", 32'(pc_plus4), 32'h0);
    np_force = 1'b0;
    tick();
    chk("wrap2.pc", 32'(pc), 32'h0);
    chk("wrap2.ipp4", 32'(ifid_pc_plus4), 32'h0);
    chk("wrap2.instr", ifid_instr, 32'hA503_FFFC);
    chk("wrap2.cnt", fetch_count, 32'd7);

    // Halt at pc=20
    np_force = 1'b1; np_val = 18'd20;
    tick();
    chk("to20.pc", 32'(pc), 32'd20);
    np_force = 1'b0; use_halt = 1'b1;
    tick();
    chk("halt.instr", ifid_instr, 32'hFFFF_FFFF);
    chk("halt.valid", 32'(ifid_valid), 32'h1);
    chk("halt.halted", 32'(halted), 32'h1);
    chk("halt.pc", 32'(pc), 32'd20);
    chk("halt.ipp4", 32'(ifid_pc_plus4), 32'd24);
    chk("halt.cnt", fetch_count, 32'd9);
    use_halt = 1'b0; np_force = 1'b1; np_val = 18'h00200;
    tick();
    chk("halt_drain.valid", 32'(ifid_valid), 32'h0);
    chk("halt_drain.instr", ifid_instr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_hold.pc", 32'(pc), 32'd20);
      chk("halt_hold.halted", 32'(halted), 32'h1);
      chk("halt_hold.cnt", fetch_count, 32'd9);
    end

    // Reset while halted
    rst = 1'b0;
    tick();
    chk_reset("rst_halt");
    rst = 1'b1; np_force = 1'b0;
    tick();
    chk("resume.pc", 32'(pc), 32'h4);
    chk("resume.cnt", fetch_count, 32'd1);
    chk("resume.valid", 32'(ifid_valid), 32'h1);

    // Reset mid-stall
    stall = 1'b1;
    tick();
    chk("stall2.pc", 32'(pc), 32'h4);
    rst = 1'b0;
    tick();
    chk_reset("rst_stall");
    rst = 1'b1; stall = 1'b0;
    tick();
    chk("resume2.pc", 32'(pc), 32'h4);
    chk("resume2.cnt", fetch_count, 32'd1);

    // Halt, then stall holds IF/ID, then flush clears it without moving pc
    use_halt = 1'b1;
    tick();
    chk("halt2.halted", 32'(halted), 32'h1);
    chk("halt2.pc", 32'(pc), 32'h4);
    use_halt = 1'b0; stall = 1'b1;
    tick();
    chk("halt2_stall.valid", 32'(ifid_valid), 32'h1);
    chk("halt2_stall.instr", ifid_instr, 32'hFFFF_FFFF);
    flush = 1'b1; np_force = 1'b1; np_val = 18'h00300;
    tick();
    chk("halt2_flush.valid", 32'(ifid_valid), 32'h0);
    chk("halt2_flush.instr", ifid_instr, 32'h0);
    chk("halt2_flush.pc", 32'(pc), 32'h4);
    chk("halt2_flush.cnt", fetch_count, 32'd2);
    flush = 1'b0; stall = 1'b0; np_force = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Owns the program counter and the IF/ID pipeline register. It sits directly upstream of the 4-to-1 next-address mux and also consumes that mux's output.
- Drives the sequential address (pc_plus4) into mux input 0 (select 2'b00) and the current PC to instruction memory.
- Loads the mux-selected next_pc each advancing cycle.
- Handles stall, flush and halt, and keeps a fetched-instruction count.

Parameters:
bit_size, 18, PC/address width in bits; matches the next-address mux width.
instr_size, 32, instruction width in bits.
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch once captured.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset.
next_pc  input  bit_size  next address from the 4-to-1 next-address mux.
instr_in  input  instr_size  instruction memory read data for address pc (combinational memory).
stall  input  1  hazard unit: hold PC and IF/ID.
flush  input  1  branch/jump taken: squash instruction being fetched.
pc  output  bit_size  current PC, instruction memory address.
pc_plus4  output  bit_size  pc+4, combinational; feeds mux select 2'b00 input.
ifid_instr  output  instr_size  registered instruction to decode.
ifid_pc_plus4  output  bit_size  registered pc+4 of that instruction.
ifid_valid  output  1  IF/ID holds a real instruction.
halted  output  1  fetch stopped by HALT_INSTR.
fetch_count  output  32  number of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset: rst sampled low at a rising clk edge sets every register to its reset value:
  - pc=0, ifid_instr=0, ifid_pc_plus4=0, ifid_valid=0, halted=0, fetch_count=0, state=RUN.
  - Reset overrides stall, flush and halt, including mid-stall and in HALT.
  - Outputs hold their reset values while rst stays low.
- pc_plus4 = pc + 4, truncated to bit_size bits (wraps modulo 2^bit_size; 18'h3FFFC -> 0). It is purely combinational from pc.
- States:
  - RUN: normal fetch.
  - HALT: PC frozen, no fetch.
- RUN, priority flush > stall > advance:
  - flush=1: pc<=next_pc; ifid_instr<=0; ifid_pc_plus4<=0; ifid_valid<=0; fetch_count unchanged. This applies even when stall=1 in the same cycle.
  - stall=1, flush=0: pc, ifid_* and fetch_count all hold.
  - Advance (stall=0, flush=0):
    - pc<=next_pc; ifid_instr<=instr_in; ifid_pc_plus4<=pc_plus4; ifid_valid<=1; fetch_count<=fetch_count+1 (wraps at 2^32).
    - If instr_in==HALT_INSTR: the same capture still occurs, and pc holds instead of loading next_pc; halted<=1; state<=HALT.
- HALT:
  - pc holds; halted stays 1.
  - First cycle in HALT with stall=0: ifid_valid<=0 and ifid_instr<=0. It stays 0 thereafter.
  - While stall=1 in HALT, IF/ID holds so decode can finish the HALT instruction.
  - flush in HALT clears IF/ID (valid=0, instr=0) but pc does not change.
  - Only rst leaves HALT.
- Latency:
  - A valid, non-flushed instruction at pc appears on ifid_* one cycle after the edge on which it was presented.
  - A redirect on next_pc takes effect on pc at the next edge.
- next_pc is used as given: no alignment check and no masking of the low 2 bits.

Test Plan:
- Reset then 3 free-running cycles, next_pc tied to pc_plus4, instr_in=mem[pc] -> pc 0,4,8,12; ifid_pc_plus4 4,8,12; ifid_valid=1 from the first edge after reset; fetch_count=3.
- Stall held 2 cycles at pc=8 -> pc, ifid_instr, fetch_count unchanged both cycles. Release -> pc=12 next edge.
- flush=1 and stall=1 together at pc=16 with next_pc=18'h00100 -> pc=18'h00100, ifid_valid=0, ifid_instr=0, fetch_count unchanged. Next cycle fetches from 18'h00100.
- pc=18'h3FFFC -> pc_plus4=0. With next_pc=pc_plus4, pc becomes 0 after the edge.
- instr_in=32'hFFFF_FFFF at pc=20 -> that edge: ifid_instr=FFFF_FFFF, valid=1, halted=1, pc stays 20. Next edge: ifid_valid=0. pc stays 20 for 5 further cycles regardless of next_pc.
- rst=0 asserted mid-stall and again while halted -> at that edge all outputs return to reset values; fetch resumes at pc=0 once rst=1.
